// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART types: line configuration enums, receiver state and the
// packet bundle handed to the downstream consumer.
package UartGlobalPkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic {
        EVEN_PARITY = 1'b0,
        ODD_PARITY  = 1'b1
    } parityTypeEnum;

    typedef enum logic [1:0] {
        ONE_STOP_BIT = 2'd1,
        TWO_STOP_BIT = 2'd2
    } stopBitEnum;

    typedef enum logic [3:0] {
        FIVE_BIT  = 4'd5,
        SIX_BIT   = 4'd6,
        SEVEN_BIT = 4'd7,
        EIGHT_BIT = 4'd8
    } dataTypeEnum;

    typedef enum logic [2:0] {
        IDLE,
        STARTBIT,
        DATABITS,
        PARITYBIT,
        STOPBIT,
        BREAKWAIT
    } UartRxStateEnum;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  parity;
        logic                  parityError;
        logic                  framingError;
        logic                  breakingError;
        logic                  overrunError;
    } UartRxPacketStruct;

    function automatic dataTypeEnum clampDataType(input logic [3:0] raw);
        if (raw < 4'd5)      return FIVE_BIT;
        else if (raw > 4'd8) return EIGHT_BIT;
        else                 return dataTypeEnum'(raw);
    endfunction

    // 0 and 1 mean one stop bit, 2 and 3 mean two.
    function automatic stopBitEnum normStopBits(input logic [1:0] raw);
        return raw[1] ? TWO_STOP_BIT : ONE_STOP_BIT;
    endfunction

    function automatic logic [4:0] clampOverSampling(input logic [4:0] raw);
        return (raw < 5'd4) ? 5'd4 : raw;
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Packet handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rxData;
    logic                  rxParity;
    logic                  parityError;
    logic                  framingError;
    logic                  breakingError;
    logic                  overrunError;
    logic                  rxValid;
    logic                  rxReady;

    modport master (
        output rxData, rxParity, parityError, framingError,
               breakingError, overrunError, rxValid,
        input  rxReady
    );

    modport slave (
        input  rxData, rxParity, parityError, framingError,
               breakingError, overrunError, rxValid,
        output rxReady
    );
endinterface

// File: rtl/uart_rx_deserializer_tick.sv
// Oversample tick generator: one-cycle tick every `divisor` clocks, phase
// realigned to the start edge through `restart`.
module uart_baud_tick_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 restart,
    output logic                 tick
);
    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] lastCount;

    // A zero divisor behaves as one: tick on every cycle.
    assign lastCount = (divisor == '0) ? '0 : divisor - DIV_WIDTH'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (restart) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count >= lastCount) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + DIV_WIDTH'(1);
            tick  <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive stage: synchronises the serial line, oversamples each frame and
// presents one packet per frame with parity/framing/break/overrun status.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] baudDivisor,
    input  logic [4:0]           overSampling,
    input  logic [3:0]           dataType,
    input  logic                 parityEnable,
    input  logic                 parityType,
    input  logic [1:0]           stopBits,
    uart_rx_deserializer_if.master rxIf
);
    import UartGlobalPkg::*;

    logic rxMeta, rxSync, rxSyncD;

    UartRxStateEnum        state;
    logic [DIV_WIDTH-1:0]  cfgDiv;
    logic [4:0]            cfgOs;
    dataTypeEnum           cfgBits;
    logic                  cfgParEn;
    parityTypeEnum         cfgParType;
    stopBitEnum            cfgStop;

    logic [4:0]            sampleCnt;
    logic [2:0]            bitIdx;
    logic                  stopIdx;
    logic [DATA_WIDTH-1:0] dataReg;
    logic                  parBit;
    logic                  parErr;
    logic                  frameErr;
    logic                  breakCand;

    UartRxPacketStruct     pkt;
    logic                  rxValidReg;

    logic       tick;
    logic       startDetect;
    logic [4:0] target;
    logic       sampleDue;
    logic [2:0] lastBit;
    logic       lastStop;
    logic       frameBreak;

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta  <= 1'b1;
            rxSync  <= 1'b1;
            rxSyncD <= 1'b1;
        end else begin
            rxMeta  <= rx;
            rxSync  <= rxMeta;
            rxSyncD <= rxSync;
        end
    end

    assign startDetect = (state == IDLE) && rxSyncD && !rxSync;

    uart_baud_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) tickGen (
        .clk     (clk),
        .reset   (reset),
        .divisor (cfgDiv),
        .restart (startDetect),
        .tick    (tick)
    );

    always_comb begin
        target     = (state == STARTBIT) ? {1'b0, cfgOs[4:1]} : cfgOs;
        sampleDue  = tick && (sampleCnt == target - 5'd1);
        lastBit    = 3'(cfgBits - 4'd1);
        lastStop   = (cfgStop == TWO_STOP_BIT);
        frameBreak = stopIdx ? breakCand : (breakCand & ~rxSync);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cfgDiv     <= '0;
            cfgOs      <= 5'd16;
            cfgBits    <= EIGHT_BIT;
            cfgParEn   <= 1'b0;
            cfgParType <= EVEN_PARITY;
            cfgStop    <= ONE_STOP_BIT;
            sampleCnt  <= '0;
            bitIdx     <= '0;
            stopIdx    <= 1'b0;
            dataReg    <= '0;
            parBit     <= 1'b0;
            parErr     <= 1'b0;
            frameErr   <= 1'b0;
            breakCand  <= 1'b0;
            pkt        <= '0;
            rxValidReg <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let a later commit override this
            // accept-clear within the same cycle, keeping rxValid high.
            if (rxValidReg && rxIf.rxReady) rxValidReg <= 1'b0;

            if (state != IDLE && state != BREAKWAIT && tick)
                sampleCnt <= sampleDue ? 5'd0 : sampleCnt + 5'd1;

            case (state)
                IDLE: begin
                    if (startDetect) begin
                        state      <= STARTBIT;
                        cfgDiv     <= baudDivisor;
                        cfgOs      <= clampOverSampling(overSampling);
                        cfgBits    <= clampDataType(dataType);
                        cfgParEn   <= parityEnable;
                        cfgParType <= parityTypeEnum'(parityType);
                        cfgStop    <= normStopBits(stopBits);
                        sampleCnt  <= '0;
                        bitIdx     <= '0;
                        stopIdx    <= 1'b0;
                        dataReg    <= '0;
                        parBit     <= 1'b0;
                        parErr     <= 1'b0;
                        frameErr   <= 1'b0;
                        breakCand  <= 1'b1;
                    end
                end

                STARTBIT: begin
                    if (sampleDue) state <= rxSync ? IDLE : DATABITS;
                end

                DATABITS: begin
                    if (sampleDue) begin
                        dataReg[bitIdx] <= rxSync;
                        breakCand       <= breakCand & ~rxSync;
                        if (bitIdx == lastBit) state <= cfgParEn ? PARITYBIT : STOPBIT;
                        else                   bitIdx <= bitIdx + 3'd1;
                    end
                end

                PARITYBIT: begin
                    if (sampleDue) begin
                        parBit    <= rxSync;
                        parErr    <= ((^dataReg) ^ rxSync) != logic'(cfgParType);
                        breakCand <= breakCand & ~rxSync;
                        state     <= STOPBIT;
                    end
                end

                STOPBIT: begin
                    if (sampleDue) begin
                        if (!rxSync) frameErr <= 1'b1;
                        if (!stopIdx) breakCand <= breakCand & ~rxSync;
                        if (stopIdx == lastStop) begin
                            if (!rxValidReg || rxIf.rxReady) begin
                                pkt <= '{data:          dataReg,
                                         parity:        parBit,
                                         parityError:   parErr,
                                         framingError:  frameErr | ~rxSync,
                                         breakingError: frameBreak,
                                         overrunError:  1'b0};
                                rxValidReg <= 1'b1;
                            end else begin
                                pkt.overrunError <= 1'b1;
                            end
                            state <= frameBreak ? BREAKWAIT : IDLE;
                        end else begin
                            stopIdx <= 1'b1;
                        end
                    end
                end

                BREAKWAIT: begin
                    if (rxSync) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign rxIf.rxData        = pkt.data;
    assign rxIf.rxParity      = pkt.parity;
    assign rxIf.parityError   = pkt.parityError;
    assign rxIf.framingError  = pkt.framingError;
    assign rxIf.breakingError = pkt.breakingError;
    assign rxIf.overrunError  = pkt.overrunError;
    assign rxIf.rxValid       = rxValidReg;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: drives serial frames bit by bit and
// compares received packets against hand-computed values.
module tb_uart_rx_deserializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] baudDivisor = 16'd1;
    logic [4:0]  overSampling = 5'd16;
    logic [3:0]  dataType = 4'd8;
    logic        parityEnable = 1'b0;
    logic        parityType = 1'b0;
    logic [1:0]  stopBits = 2'd1;

    int assertCount = 0;
    int failCount = 0;
    int bitCycles = 16;
    int validCycles = 0;

    logic [7:0] lastData = 8'h00;
    logic       lastParity = 1'b0;
    logic       lastPe = 1'b0;
    logic       lastFe = 1'b0;
    logic       lastBe = 1'b0;
    logic       lastOe = 1'b0;

    uart_rx_deserializer_if #(.DATA_WIDTH(8)) rxIf ();

    uart_rx_deserializer #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .baudDivisor  (baudDivisor),
        .overSampling (overSampling),
        .dataType     (dataType),
        .parityEnable (parityEnable),
        .parityType   (parityType),
        .stopBits     (stopBits),
        .rxIf         (rxIf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rxIf.rxValid) begin
            validCycles = validCycles + 1;
            lastData    = rxIf.rxData;
            lastParity  = rxIf.rxParity;
            lastPe      = rxIf.parityError;
            lastFe      = rxIf.framingError;
            lastBe      = rxIf.breakingError;
            lastOe      = rxIf.overrunError;
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setConfig(input int div, input int os, input int bits,
                             input logic pe, input logic pt, input int sb);
        baudDivisor  = 16'(div);
        overSampling = 5'(os);
        dataType     = 4'(bits);
        parityEnable = pe;
        parityType   = pt;
        stopBits     = 2'(sb);
        bitCycles    = div * os;
    endtask

    task automatic driveBit(input logic b);
        rx = b;
        repeat (bitCycles) @(negedge clk);
    endtask

    task automatic idleBits(input int n);
        rx = 1'b1;
        repeat (n * bitCycles) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] data, input int nBits, input logic pe,
                             input logic parBit, input int nStop, input logic lastStopVal);
        driveBit(1'b0);
        for (int i = 0; i < nBits; i++) driveBit(data[i]);
        if (pe) driveBit(parBit);
        for (int i = 0; i < nStop; i++) driveBit((i == nStop - 1) ? lastStopVal : 1'b1);
        rx = 1'b1;
    endtask

    task automatic checkOutputsZero(input string tag);
        check({tag, "_valid"}, rxIf.rxValid, 0);
        check({tag, "_data"}, rxIf.rxData, 0);
        check({tag, "_par"}, rxIf.rxParity, 0);
        check({tag, "_pe"}, rxIf.parityError, 0);
        check({tag, "_fe"}, rxIf.framingError, 0);
        check({tag, "_be"}, rxIf.breakingError, 0);
        check({tag, "_oe"}, rxIf.overrunError, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rxIf.rxReady = 1'b1;
        repeat (3) @(negedge clk);
        checkOutputsZero("rst_hold");
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_release_valid", rxIf.rxValid, 0);

        // 8N1, 0xA5
        setConfig(1, 16, 8, 1'b0, 1'b0, 1);
        validCycles = 0;
        sendFrame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
        idleBits(2);
        check("8n1_pulse_cycles", validCycles, 1);
        check("8n1_data", lastData, 8'hA5);
        check("8n1_par", lastParity, 0);
        check("8n1_pe", lastPe, 0);
        check("8n1_fe", lastFe, 0);
        check("8n1_be", lastBe, 0);
        check("8n1_oe", lastOe, 0);

        // 7E1, 0x35 has four ones: correct even parity bit is 0
        setConfig(1, 16, 7, 1'b1, 1'b0, 1);
        validCycles = 0;
        sendFrame(8'h35, 7, 1'b1, 1'b1, 1, 1'b1);
        idleBits(2);
        check("7e1_bad_count", validCycles, 1);
        check("7e1_bad_data", lastData, 8'h35);
        check("7e1_bad_parbit", lastParity, 1);
        check("7e1_bad_pe", lastPe, 1);
        validCycles = 0;
        sendFrame(8'h35, 7, 1'b1, 1'b0, 1, 1'b1);
        idleBits(2);
        check("7e1_ok_count", validCycles, 1);
        check("7e1_ok_data", lastData, 8'h35);
        check("7e1_ok_pe", lastPe, 0);
        check("7e1_ok_fe", lastFe, 0);

        // 8N2, second stop bit low
        setConfig(1, 16, 8, 1'b0, 1'b0, 2);
        validCycles = 0;
        sendFrame(8'h3C, 8, 1'b0, 1'b0, 2, 1'b0);
        idleBits(2);
        check("8n2_count", validCycles, 1);
        check("8n2_data", lastData, 8'h3C);
        check("8n2_fe", lastFe, 1);
        check("8n2_be", lastBe, 0);

        // 8O1 break: line low for 12 bit times, divisor 3, 13x oversampling
        setConfig(3, 13, 8, 1'b1, 1'b1, 1);
        validCycles = 0;
        rx = 1'b0;
        repeat (12 * bitCycles) @(negedge clk);
        idleBits(3);
        check("brk_count", validCycles, 1);
        check("brk_data", lastData, 8'h00);
        check("brk_be", lastBe, 1);
        check("brk_fe", lastFe, 1);
        // 0xC3 has four ones: odd parity bit is 1
        validCycles = 0;
        sendFrame(8'hC3, 8, 1'b1, 1'b1, 1, 1'b1);
        idleBits(2);
        check("post_brk_count", validCycles, 1);
        check("post_brk_data", lastData, 8'hC3);
        check("post_brk_be", lastBe, 0);
        check("post_brk_pe", lastPe, 0);

        // Overrun: consumer stalled across two frames
        setConfig(1, 16, 8, 1'b0, 1'b0, 1);
        rxIf.rxReady = 1'b0;
        sendFrame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
        idleBits(1);
        check("ovr_first_valid", rxIf.rxValid, 1);
        check("ovr_first_data", rxIf.rxData, 8'h11);
        check("ovr_first_oe", rxIf.overrunError, 0);
        sendFrame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
        idleBits(1);
        check("ovr_held_valid", rxIf.rxValid, 1);
        check("ovr_held_data", rxIf.rxData, 8'h11);
        check("ovr_held_oe", rxIf.overrunError, 1);
        rxIf.rxReady = 1'b1;
        @(negedge clk);
        check("ovr_after_accept_valid", rxIf.rxValid, 0);

        // Glitch shorter than half a bit is a false start
        validCycles = 0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idleBits(3);
        check("glitch_count", validCycles, 0);

        // Reset during data bits drops the frame and clears held outputs
        validCycles = 0;
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        rx = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutputsZero("midrst");
        reset = 1'b1;
        idleBits(3);
        check("midrst_no_pkt", validCycles, 0);
        sendFrame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
        idleBits(2);
        check("midrst_next_count", validCycles, 1);
        check("midrst_next_data", lastData, 8'h5A);
        check("midrst_next_fe", lastFe, 0);
        check("midrst_next_oe", lastOe, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Synthesizable UART receive stage that consumes the serial line driven by the UART transmitter and produces one parallel data packet per frame, with parity, framing, break and overrun status. It oversamples the line using a programmable clock divisor and presents each packet on a valid/ready handshake to the downstream consumer (monitor or scoreboard adapter). Configuration inputs mirror the fields of `UartConfigStruct`.

## Interface
- `DATA_WIDTH`, 8, maximum data bits per frame (matches package `DATA_WIDTH`)
- `DIV_WIDTH`, 16, width of the oversample clock divisor
- `clk` input 1, system clock
- `reset` input 1, asynchronous, active-low reset; one clock domain only
- `rx` input 1, serial line, idle high, asynchronous to `clk`
- `baudDivisor` input DIV_WIDTH, `clk` cycles per oversample tick; 0 treated as 1
- `overSampling` input 5, ticks per bit (16 or 13; any value 4..31 accepted)
- `dataType` input 4, data bits per frame, 5..8; values outside are clamped to that range
- `parityEnable` input 1, 1 = parity bit present
- `parityType` input 1, 0 = EVEN_PARITY, 1 = ODD_PARITY
- `stopBits` input 2, 1 or 2 (0 treated as 1, 3 as 2)
- `rxData` output DATA_WIDTH, received data, LSB first on line, unused upper bits 0
- `rxParity` output 1, received parity bit (0 if disabled)
- `parityError`, `framingError`, `breakingError`, `overrunError` output 1 each
- `rxValid` output 1, packet available
- `rxReady` input 1, consumer accepts packet when `rxValid && rxReady`

## Operation
- `rx` passes through a 2-flop synchronizer, reset value 1; all decisions use the synced value.
- Tick generator: counter pulses `tick` every `baudDivisor` cycles; runs continuously, restarts at 0 on start-edge detection.
- State machine `UartRxStateEnum`: IDLE, STARTBIT, DATABITS, PARITYBIT, STOPBIT, BREAKWAIT.
- IDLE: synced line 1->0 transition -> STARTBIT, tick and sample counters cleared.
- STARTBIT: at tick count `overSampling>>1` sample line; 0 -> DATABITS, sample counter cleared; 1 -> false start, back to IDLE, no output.
- DATABITS: sample every `overSampling` ticks; shift into bit index 0..dataType-1; after last bit -> PARITYBIT if enabled, else STOPBIT.
- PARITYBIT: one sample; `parityError` = (XOR of data bits and parity bit) != `parityType`.
- STOPBIT: sample `stopBits` times; any 0 sample sets `framingError`. After last stop sample: commit packet, -> IDLE, or -> BREAKWAIT on break.
- Break: all data bits, parity bit (if enabled) and first stop sample 0 -> `breakingError`=1 and `framingError`=1; BREAKWAIT holds until synced line is 1, then IDLE.
- Config inputs are sampled at STARTBIT entry and held for the frame.
- Commit: if `rxValid`=0 or accepted same cycle, load output register and set `rxValid`. If `rxValid`=1 and `rxReady`=0, new frame is discarded and held packet's `overrunError` set to 1.
- `rxValid` clears on accept when no commit occurs in that cycle; commit and accept in same cycle load the new packet with `rxValid` staying 1.

## Timing
- Reset (asynchronous): state IDLE, counters 0, synchronizer 1, all outputs 0, including `rxValid`.
- Reset asserted mid-frame: frame dropped, no packet produced; on release waits for a new falling edge.
- Synchronizer latency 2 cycles; start edge recognised 3 cycles after `rx` falls.
- Data bit n sampled at `(overSampling>>1) + (n+1)*overSampling` ticks after the edge.
- `rxValid` rises the cycle after the final stop-bit sample.
- Outputs are stable while `rxValid`=1 except `overrunError` 0->1.

## Structure
- Add `UartRxStateEnum` and the `UartRxPacketStruct` output bundling to `UartGlobalPkg`; reuse `parityTypeEnum`, `stopBitEnum`, `dataTypeEnum`.
- One sub-module: `uart_baud_tick_gen` (divisor counter with restart and `tick` output).

## Test plan
- 8N1, divisor 1, overSampling 16, frame 0xA5, `rxReady`=1 -> `rxData`=0xA5, `rxValid` pulses 1 cycle, all error flags 0.
- 7E1, 0x35, parity bit forced 1 -> `rxData`=0x35, `parityError`=1; same frame with correct parity 0 -> `parityError`=0.
- 8N2, 0x3C, second stop bit driven 0 -> `framingError`=1, `breakingError`=0.
- Line held 0 for 12 bit times, 8O1 -> `rxData`=0x00, `breakingError`=1, `framingError`=1; no further packet until line high and new start.
- `rxReady`=0, two frames 0x11 then 0x22 -> held `rxData`=0x11 with `overrunError`=1; after accept `rxValid`=0.
- 0-pulse of 4 `clk` cycles (glitch) with overSampling 16 -> no packet; `reset` pulsed during DATABITS -> outputs 0, next frame 0x5A received correctly.
